vc_buffer_array: RTL and testbench

- Multi-virtual-channel input buffer for a router input port. Holds one independent FIFO per VC, with a VC index on the write side.
- Drives a single output flit stream to the router control logic. A round-robin arbiter picks among non-empty VCs.
- An optional packet-lock mode holds the grant on one VC until its tail flit leaves.
- Reports per-VC occupancy for credit generation, plus a sticky protocol-error flag.

---
 rtl/vc_buffer_array.sv | 192 +++++++++++++++++++
 tb/tb_vc_buffer_array.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_buffer_array.sv
// vc_buffer_array: per-VC input FIFOs for one router input port, with a
// round-robin output arbiter, optional packet lock, a grant hold register
// that keeps a stalled output stable, per-VC occupancy and a sticky error flag.
module vc_buffer_array #(
  parameter  int N_VC     = 3,
  parameter  int DEPTH    = 4,
  parameter  int WIDTH    = 34,
  parameter  int PKT_LOCK = 1,
  localparam int VC_W     = (N_VC > 1) ? $clog2(N_VC) : 1,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic [WIDTH-1:0]        fdata_i,
  input  logic [VC_W-1:0]         vc_id_i,
  input  logic                    last_i,
  input  logic                    valid_i,
  output logic [N_VC-1:0]         ready_o,
  output logic [WIDTH-1:0]        fdata_o,
  output logic [VC_W-1:0]         vc_id_o,
  output logic                    last_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [N_VC*CNT_W-1:0]   occ_o,
  output logic                    error_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Advance a FIFO slot pointer, wrapping at DEPTH (DEPTH need not be 2^n).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      ptr_inc = {PTR_W{1'b0}};
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  // Candidate VC at offset i after the round-robin pointer, modulo N_VC.
  function automatic logic [VC_W-1:0] rr_idx(input logic [VC_W-1:0] p, input int i);
    rr_idx = VC_W'((int'(p) + i) % N_VC);
  endfunction

  logic [N_VC-1:0]  empty_s;
  logic [N_VC-1:0]  full_s;
  logic [WIDTH:0]   head_arr_s [N_VC];
  logic [WIDTH:0]   head_s;
  logic             vc_in_range_s;
  logic             wr_full_s;
  logic             wr_en_s;
  logic             wr_err_s;
  logic             pop_s;
  logic [VC_W-1:0]  rr_vc_s;
  logic             rr_found_s;
  logic [VC_W-1:0]  grant_s;
  logic [VC_W-1:0]  rr_ptr_r;
  logic             lock_vld_r;
  logic [VC_W-1:0]  lock_vc_r;
  logic             hold_vld_r;
  logic [VC_W-1:0]  hold_vc_r;
  logic             err_r;

  assign vc_in_range_s = (32'(vc_id_i) < 32'(N_VC));

  // Look up whether the addressed VC is full; out-of-range ids never index.
  always_comb begin
    wr_full_s = 1'b0;
    if (vc_in_range_s) begin
      wr_full_s = full_s[vc_id_i];
    end else begin
      wr_full_s = 1'b0;
    end
  end

  assign wr_en_s  = valid_i && vc_in_range_s && !wr_full_s;
  assign wr_err_s = valid_i && (!vc_in_range_s || wr_full_s);

  for (genvar v = 0; v < N_VC; v++) begin : g_vc
    logic [WIDTH:0]     mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               wr_s;
    logic               rd_s;

    assign wr_s          = wr_en_s && (vc_id_i == VC_W'(v));
    assign rd_s          = pop_s && (grant_s == VC_W'(v));
    assign empty_s[v]    = (cnt_r == {CNT_W{1'b0}});
    assign full_s[v]     = (cnt_r == CNT_W'(DEPTH));
    assign head_arr_s[v] = mem_r[rd_ptr_r];
    assign occ_o[v*CNT_W +: CNT_W] = cnt_r;

    // FIFO pointers and exact occupancy count for this VC.
    always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
        wr_ptr_r <= {PTR_W{1'b0}};
        rd_ptr_r <= {PTR_W{1'b0}};
        cnt_r    <= {CNT_W{1'b0}};
      end else begin
        if (wr_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
        else      wr_ptr_r <= wr_ptr_r;
        if (rd_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
        else      rd_ptr_r <= rd_ptr_r;
        case ({wr_s, rd_s})
          2'b10:   cnt_r <= cnt_r + CNT_W'(1);
          2'b01:   cnt_r <= cnt_r - CNT_W'(1);
          default: cnt_r <= cnt_r;
        endcase
      end
    end

    // Flit storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
      if (wr_s) begin
        mem_r[wr_ptr_r] <= {last_i, fdata_i};
      end
    end
  end

  // Round-robin search for the first non-empty VC after the pointer.
  always_comb begin
    rr_found_s = 1'b0;
    rr_vc_s    = rr_ptr_r;
    for (int i = 1; i <= N_VC; i++) begin
      if (!rr_found_s && !empty_s[rr_idx(rr_ptr_r, i)]) begin
        rr_found_s = 1'b1;
        rr_vc_s    = rr_idx(rr_ptr_r, i);
      end else begin
        rr_found_s = rr_found_s;
      end
    end
  end

  // Grant priority: packet lock, then stall hold, then round-robin.
  always_comb begin
    grant_s = rr_vc_s;
    if (lock_vld_r) begin
      grant_s = lock_vc_r;
    end else if (hold_vld_r) begin
      grant_s = hold_vc_r;
    end else begin
      grant_s = rr_vc_s;
    end
  end

  assign head_s  = head_arr_s[grant_s];
  assign valid_o = !empty_s[grant_s];
  assign fdata_o = head_s[WIDTH-1:0];
  assign last_o  = head_s[WIDTH];
  assign vc_id_o = grant_s;
  assign pop_s   = valid_o && ready_i;
  assign ready_o = ~full_s;
  assign error_o = err_r;

  // Arbitration state: rr pointer, packet lock, stall hold and sticky error.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      rr_ptr_r   <= VC_W'(N_VC - 1);
      lock_vld_r <= 1'b0;
      lock_vc_r  <= {VC_W{1'b0}};
      hold_vld_r <= 1'b0;
      hold_vc_r  <= {VC_W{1'b0}};
      err_r      <= 1'b0;
    end else begin
      err_r <= err_r | wr_err_s;
      if (pop_s) begin
        rr_ptr_r   <= grant_s;
        hold_vld_r <= 1'b0;
        hold_vc_r  <= hold_vc_r;
        if (PKT_LOCK != 0) begin
          lock_vld_r <= !last_o;
          lock_vc_r  <= grant_s;
        end else begin
          lock_vld_r <= 1'b0;
          lock_vc_r  <= lock_vc_r;
        end
      end else begin
        rr_ptr_r   <= rr_ptr_r;
        lock_vld_r <= lock_vld_r;
        lock_vc_r  <= lock_vc_r;
        if (valid_o) begin
          hold_vld_r <= 1'b1;
          hold_vc_r  <= grant_s;
        end else begin
          hold_vld_r <= 1'b0;
          hold_vc_r  <= hold_vc_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_vc_buffer_array.sv
// tb_vc_buffer_array: directed bench for vc_buffer_array with N_VC=3,
// DEPTH=2, WIDTH=8. One instance with packet lock, one without, sharing stimulus.
module tb_vc_buffer_array;

  logic       clk;
  logic       arst;
  logic [7:0] fdata_i;
  logic [1:0] vc_id_i;
  logic       last_i;
  logic       valid_i;
  logic       ready_i;

  logic [2:0] lk_ready_o, nl_ready_o;
  logic [7:0] lk_fdata_o, nl_fdata_o;
  logic [1:0] lk_vc_id_o, nl_vc_id_o;
  logic       lk_last_o, nl_last_o;
  logic       lk_valid_o, nl_valid_o;
  logic [5:0] lk_occ_o, nl_occ_o;
  logic       lk_error_o, nl_error_o;

  int n_vec = 0;
  int n_err = 0;

  vc_buffer_array #(.N_VC(3), .DEPTH(2), .WIDTH(8), .PKT_LOCK(1)) dut_lk (
    .clk(clk), .arst(arst), .fdata_i(fdata_i), .vc_id_i(vc_id_i),
    .last_i(last_i), .valid_i(valid_i), .ready_o(lk_ready_o),
    .fdata_o(lk_fdata_o), .vc_id_o(lk_vc_id_o), .last_o(lk_last_o),
    .valid_o(lk_valid_o), .ready_i(ready_i), .occ_o(lk_occ_o),
    .error_o(lk_error_o)
  );

  vc_buffer_array #(.N_VC(3), .DEPTH(2), .WIDTH(8), .PKT_LOCK(0)) dut_nl (
    .clk(clk), .arst(arst), .fdata_i(fdata_i), .vc_id_i(vc_id_i),
    .last_i(last_i), .valid_i(valid_i), .ready_o(nl_ready_o),
    .fdata_o(nl_fdata_o), .vc_id_o(nl_vc_id_o), .last_o(nl_last_o),
    .valid_o(nl_valid_o), .ready_i(ready_i), .occ_o(nl_occ_o),
    .error_o(nl_error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic push(input logic [1:0] vc, input logic [7:0] d, input logic l);
    vc_id_i = vc;
    fdata_i = d;
    last_i  = l;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic reset_pulse();
    arst = 1'b0;
    settle();
    chk("rst_valid", 32'(lk_valid_o), 32'd0);
    chk("rst_ready", 32'(lk_ready_o), 32'h7);
    chk("rst_occ", 32'(lk_occ_o), 32'h0);
    chk("rst_err", 32'(lk_error_o), 32'd0);
    tick();
    arst = 1'b1;
  endtask

  initial begin
    arst    = 1'b1;
    fdata_i = 8'h00;
    vc_id_i = 2'd0;
    last_i  = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    #1;
    reset_pulse();
    tick();
    settle();
    chk("idle_valid", 32'(lk_valid_o), 32'd0);
    chk("idle_ready", 32'(lk_ready_o), 32'h7);

    // Two flits through VC1, occupancy 2 -> 1 -> 0
    push(2'd1, 8'h11, 1'b1);
    settle();
    chk("t2_occ1", 32'(lk_occ_o), 32'h04);
    push(2'd1, 8'h12, 1'b1);
    settle();
    chk("t2_ready_full", 32'(lk_ready_o), 32'h5);
    chk("t2_occ2", 32'(lk_occ_o), 32'h08);
    chk("t2_data0", 32'(lk_fdata_o), 32'h11);
    chk("t2_vc0", 32'(lk_vc_id_o), 32'd1);
    ready_i = 1'b1;
    tick();
    settle();
    chk("t2_data1", 32'(lk_fdata_o), 32'h12);
    chk("t2_occ_after1", 32'(lk_occ_o), 32'h04);
    chk("t2_ready_again", 32'(lk_ready_o), 32'h7);
    tick();
    settle();
    chk("t2_empty", 32'(lk_valid_o), 32'd0);
    chk("t2_occ_after2", 32'(lk_occ_o), 32'h00);
    ready_i = 1'b0;

    // Round-robin without packet lock: A0, C0, A1, C1
    reset_pulse();
    push(2'd0, 8'hA0, 1'b0);
    push(2'd0, 8'hA1, 1'b0);
    push(2'd2, 8'hC0, 1'b0);
    push(2'd2, 8'hC1, 1'b0);
    ready_i = 1'b1;
    settle();
    chk("rr_d0", 32'(nl_fdata_o), 32'hA0);
    chk("rr_v0", 32'(nl_vc_id_o), 32'd0);
    tick();
    settle();
    chk("rr_d1", 32'(nl_fdata_o), 32'hC0);
    chk("rr_v1", 32'(nl_vc_id_o), 32'd2);
    tick();
    settle();
    chk("rr_d2", 32'(nl_fdata_o), 32'hA1);
    tick();
    settle();
    chk("rr_d3", 32'(nl_fdata_o), 32'hC1);
    tick();
    settle();
    chk("rr_done", 32'(nl_valid_o), 32'd0);
    ready_i = 1'b0;

    // Packet lock: A0, gap while VC0 empty, A1, then C0
    reset_pulse();
    push(2'd0, 8'hA0, 1'b0);
    push(2'd2, 8'hC0, 1'b1);
    ready_i = 1'b1;
    settle();
    chk("lk_d0", 32'(lk_fdata_o), 32'hA0);
    chk("lk_l0", 32'(lk_last_o), 32'd0);
    tick();
    settle();
    chk("lk_gap1", 32'(lk_valid_o), 32'd0);
    tick();
    settle();
    chk("lk_gap2", 32'(lk_valid_o), 32'd0);
    tick();
    vc_id_i = 2'd0;
    fdata_i = 8'hA1;
    last_i  = 1'b1;
    valid_i = 1'b1;
    settle();
    chk("lk_gap3", 32'(lk_valid_o), 32'd0);
    tick();
    valid_i = 1'b0;
    settle();
    chk("lk_d1", 32'(lk_fdata_o), 32'hA1);
    chk("lk_l1", 32'(lk_last_o), 32'd1);
    chk("lk_v1", 32'(lk_vc_id_o), 32'd0);
    tick();
    settle();
    chk("lk_d2", 32'(lk_fdata_o), 32'hC0);
    chk("lk_v2", 32'(lk_vc_id_o), 32'd2);
    tick();
    settle();
    chk("lk_done", 32'(lk_valid_o), 32'd0);
    ready_i = 1'b0;

    // Stall: C0 on VC2 held while VC0 fills
    reset_pulse();
    push(2'd2, 8'hC0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("stall_data", 32'(lk_fdata_o), 32'hC0);
      chk("stall_vc", 32'(lk_vc_id_o), 32'd2);
      if (i < 2) begin
        vc_id_i = 2'd0;
        fdata_i = 8'hB0 + 8'(i);
        last_i  = 1'b1;
        valid_i = 1'b1;
      end
      tick();
      valid_i = 1'b0;
    end
    settle();
    chk("stall_occ", 32'(lk_occ_o), 32'h12);
    ready_i = 1'b1;
    settle();
    chk("stall_rel", 32'(lk_fdata_o), 32'hC0);
    tick();
    settle();
    chk("stall_next_d", 32'(lk_fdata_o), 32'hB0);
    chk("stall_next_v", 32'(lk_vc_id_o), 32'd0);
    tick();
    settle();
    chk("stall_next2", 32'(lk_fdata_o), 32'hB1);
    tick();
    ready_i = 1'b0;

    // Write to a full VC: dropped, error sticky
    reset_pulse();
    push(2'd1, 8'h21, 1'b1);
    push(2'd1, 8'h22, 1'b1);
    settle();
    chk("err_pre", 32'(lk_error_o), 32'd0);
    push(2'd1, 8'h23, 1'b1);
    settle();
    chk("err_full_occ", 32'(lk_occ_o), 32'h08);
    chk("err_full_flag", 32'(lk_error_o), 32'd1);
    tick();
    settle();
    chk("err_full_hold", 32'(lk_error_o), 32'd1);
    ready_i = 1'b1;
    settle();
    chk("err_drain0", 32'(lk_fdata_o), 32'h21);
    tick();
    settle();
    chk("err_drain1", 32'(lk_fdata_o), 32'h22);
    tick();
    settle();
    chk("err_dropped", 32'(lk_valid_o), 32'd0);
    ready_i = 1'b0;

    // Out-of-range VC id: dropped, error sticky, cleared by reset
    reset_pulse();
    push(2'd3, 8'h33, 1'b1);
    settle();
    chk("err_id_flag", 32'(lk_error_o), 32'd1);
    chk("err_id_occ", 32'(lk_occ_o), 32'h00);
    chk("err_id_valid", 32'(lk_valid_o), 32'd0);
    reset_pulse();
    settle();
    chk("err_cleared", 32'(lk_error_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
